midi_tx_arbiter: RTL and testbench
==================================

Name: midi_tx_arbiter

Overview:
Shares the single MIDI OUT transmitter between several message sources, such as button-triggered commands and MIDI-thru of received commands. Each source holds a complete message (status, data1, data2, byte count) with a req/ack handshake. The arbiter grants sources round-robin, loads the transmitter's command registers, pulses its trigger and tracks transmitter busy. It enforces a minimum idle gap between messages and reports transmitters that never start.

Parameters:
N_REQ, 2, number of requesters (2..8)
GAP_CYCLES, 3200, clk cycles of enforced idle after tx_busy falls (0 = none)
START_TIMEOUT, 6400, clk cycles to wait for tx_busy after trigger before abort

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
req  input  N_REQ  per-source request, level, held until ack
req_status  input  8*N_REQ  status byte, source i at [8i+7:8i]
req_data1  input  8*N_REQ  first data byte
req_data2  input  8*N_REQ  second data byte
req_len  input  2*N_REQ  message bytes 0..3
ack  output  N_REQ  one-cycle pulse, message of source i accepted
tx_status  output  8  to transmitter
tx_data1  output  8  to transmitter
tx_data2  output  8  to transmitter
tx_bits  output  8  bits to send = req_len*10
tx_trigger  output  1  level, start request to transmitter
tx_busy  input  1  transmitter shifting a message
grant_idx  output  3  index of last granted source
err_timeout  output  1  one-cycle pulse, start timeout hit

Behaviour:
- Reset (async, rst=1): state IDLE; ack=0, tx_status/tx_data1/tx_data2/tx_bits=0, tx_trigger=0, grant_idx=N_REQ-1 (first search starts at 0), err_timeout=0, counters=0.
- All outputs registered. States: IDLE, TRIG, BUSY, GAP.
- IDLE: if any req bit set at edge k, pick g = first set index searching grant_idx+1, grant_idx+2, ... modulo N_REQ. At edge k+1: grant_idx=g, ack[g]=1 for exactly this cycle, tx_* latched from source g, tx_bits=req_len[g]*10 (8-bit result, max 30).
  - req_len[g]!=0: tx_trigger=1, state TRIG, timeout counter cleared.
  - req_len[g]==0: message dropped, ack still pulsed, no trigger, state stays IDLE. Rotation still advances to g.
- Requester may deassert req or present a new message the cycle after ack. req seen again after ack is a new message.
- TRIG: tx_trigger held 1.
  - tx_busy=1: next edge tx_trigger=0, state BUSY.
  - Counter reaches START_TIMEOUT-1 without tx_busy: tx_trigger=0, err_timeout pulse 1 cycle, state GAP.
- BUSY: tx_busy=0 -> state GAP with gap counter cleared. If GAP_CYCLES=0, go directly to IDLE.
- GAP: count GAP_CYCLES cycles, then IDLE. New grants are taken only from IDLE, so the minimum spacing from tx_busy falling to the next tx_trigger rise is GAP_CYCLES+2 cycles.
- tx_* data outputs stay stable from load until the next grant. They are never changed while in TRIG or BUSY.
- Requests arriving during TRIG, BUSY or GAP wait. Arbitration uses req as sampled on the IDLE edge only.
- Simultaneous requests: exactly one ack per grant. Round-robin guarantees each active source is granted within N_REQ messages.
- tx_busy already high in IDLE (transmitter still busy from elsewhere): the arbiter still grants; TRIG then exits on the first cycle. Integration must ensure this does not occur.
- Reset mid-message: all state and outputs return to reset values immediately. The pending message is lost and its requester gets no ack.

Test Plan:
- N_REQ=2, GAP_CYCLES=4, START_TIMEOUT=16; req[0] with B0/2E/7F len 3; transmitter model asserts busy 2 cycles after trigger for 10 cycles -> ack[0] pulses once, tx_bits=30, tx_trigger falls the cycle after busy rises, next grant no earlier than 6 cycles after busy falls.
- req[0] and req[1] held together continuously -> grant order 0,1,0,1; grant_idx alternates; each ack one cycle wide, never both.
- req[1] with C0/42 len 2 -> tx_status=C0, tx_data1=42, tx_bits=20; tx_* unchanged throughout BUSY.
- Transmitter model never asserts busy -> tx_trigger high exactly 16 cycles, err_timeout pulses once, then after the 4-cycle GAP the next pending req is granted.
- req[0] with len 0 -> ack[0] pulses, tx_trigger stays 0, grant_idx=0, a following req[1] is granted the next IDLE cycle.
- rst asserted during BUSY -> all outputs 0 and grant_idx=1 asynchronously; after release req[0] is granted first.

Source files
------------

// File: rtl/midi_tx_arbiter.sv
// Round-robin arbiter sharing one MIDI OUT transmitter between several message sources.
// Loads the transmitter command registers, triggers it, tracks busy and enforces an idle gap.
module midi_tx_arbiter #(
   parameter int N_REQ         = 2,
   parameter int GAP_CYCLES    = 3200,
   parameter int START_TIMEOUT = 6400
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req,
   input  logic [8*N_REQ-1:0]   req_status,
   input  logic [8*N_REQ-1:0]   req_data1,
   input  logic [8*N_REQ-1:0]   req_data2,
   input  logic [2*N_REQ-1:0]   req_len,
   output logic [N_REQ-1:0]     ack,
   output logic [7:0]           tx_status,
   output logic [7:0]           tx_data1,
   output logic [7:0]           tx_data2,
   output logic [7:0]           tx_bits,
   output logic                 tx_trigger,
   input  logic                 tx_busy,
   output logic [2:0]           grant_idx,
   output logic                 err_timeout
);

   localparam int TW = $clog2(START_TIMEOUT + 2);
   localparam int GW = $clog2(GAP_CYCLES + 2);
   localparam logic [TW-1:0] TO_LAST  = TW'((START_TIMEOUT > 0) ? START_TIMEOUT - 1 : 0);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, TRIG, BUSY, GAP} state_t;

   state_t           state, next_state;
   logic [TW-1:0]    tcnt, tcnt_nxt;
   logic [GW-1:0]    gcnt, gcnt_nxt;
   logic [N_REQ-1:0] ack_nxt;
   logic [7:0]       status_nxt, data1_nxt, data2_nxt, bits_nxt;
   logic             trig_nxt, err_nxt;
   logic [2:0]       grant_nxt;

   logic [N_REQ-1:0] pick_oh;
   logic [2:0]       pick;
   logic [7:0]       pick_status, pick_data1, pick_data2;
   logic [1:0]       pick_len;
   logic             any_req, gap_done, timeout_hit;
   int               arb_best, arb_dist;

   assign any_req     = |req;
   assign gap_done    = (GAP_CYCLES == 0) || (gcnt == GAP_LAST);
   assign timeout_hit = (tcnt == TO_LAST);

   // Winner is the requester at the smallest rotational distance after the last grant.
   always_comb begin
      pick        = grant_idx;
      pick_oh     = '0;
      pick_status = '0;
      pick_data1  = '0;
      pick_data2  = '0;
      pick_len    = '0;
      arb_best    = N_REQ;
      arb_dist    = 0;
      for (int i = 0; i < N_REQ; i++) begin
         arb_dist = (i + 2 * N_REQ - 1 - int'(grant_idx)) % N_REQ;
         if (req[i] && (arb_dist < arb_best)) begin
            arb_best    = arb_dist;
            pick        = 3'(i);
            pick_oh     = '0;
            pick_oh[i]  = 1'b1;
            pick_status = req_status[8*i +: 8];
            pick_data1  = req_data1[8*i +: 8];
            pick_data2  = req_data2[8*i +: 8];
            pick_len    = req_len[2*i +: 2];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         tcnt        <= '0;
         gcnt        <= '0;
         ack         <= '0;
         tx_status   <= '0;
         tx_data1    <= '0;
         tx_data2    <= '0;
         tx_bits     <= '0;
         tx_trigger  <= 1'b0;
         grant_idx   <= 3'(N_REQ - 1);
         err_timeout <= 1'b0;
      end else begin
         state       <= next_state;
         tcnt        <= tcnt_nxt;
         gcnt        <= gcnt_nxt;
         ack         <= ack_nxt;
         tx_status   <= status_nxt;
         tx_data1    <= data1_nxt;
         tx_data2    <= data2_nxt;
         tx_bits     <= bits_nxt;
         tx_trigger  <= trig_nxt;
         grant_idx   <= grant_nxt;
         err_timeout <= err_nxt;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (any_req && (pick_len != 2'd0)) next_state = TRIG;
         TRIG: begin
            if (tx_busy)          next_state = BUSY;
            else if (timeout_hit) next_state = GAP;
         end
         BUSY: if (!tx_busy) next_state = (GAP_CYCLES == 0) ? IDLE : GAP;
         GAP:  if (gap_done) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // A zero-length message is acknowledged and dropped without touching the transmitter.
   always_comb begin
      ack_nxt    = '0;
      err_nxt    = 1'b0;
      trig_nxt   = tx_trigger;
      status_nxt = tx_status;
      data1_nxt  = tx_data1;
      data2_nxt  = tx_data2;
      bits_nxt   = tx_bits;
      grant_nxt  = grant_idx;
      tcnt_nxt   = tcnt;
      gcnt_nxt   = gcnt;
      case (state)
         IDLE: begin
            if (any_req) begin
               ack_nxt    = pick_oh;
               grant_nxt  = pick;
               status_nxt = pick_status;
               data1_nxt  = pick_data1;
               data2_nxt  = pick_data2;
               bits_nxt   = 8'(pick_len) * 8'd10;
               trig_nxt   = (pick_len != 2'd0);
               tcnt_nxt   = '0;
            end
         end
         TRIG: begin
            if (tx_busy) begin
               trig_nxt = 1'b0;
            end else if (timeout_hit) begin
               trig_nxt = 1'b0;
               err_nxt  = 1'b1;
               gcnt_nxt = '0;
            end else begin
               tcnt_nxt = tcnt + 1'b1;
            end
         end
         BUSY: if (!tx_busy) gcnt_nxt = '0;
         GAP:  if (!gap_done) gcnt_nxt = gcnt + 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_midi_tx_arbiter.sv
// Randomized scoreboard bench for midi_tx_arbiter with a transaction-level arbitration model.
module tb_midi_tx_arbiter;
   localparam int N_REQ    = 2;
   localparam int GAP      = 4;
   localparam int TOUT     = 16;
   localparam int BUSY_LEN = 10;

   typedef struct packed {
      logic [7:0] st;
      logic [7:0] d1;
      logic [7:0] d2;
      logic [1:0] len;
   } msg_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [N_REQ-1:0]     req;
   logic [8*N_REQ-1:0]   req_status, req_data1, req_data2;
   logic [2*N_REQ-1:0]   req_len;
   logic [N_REQ-1:0]     ack;
   logic [7:0]           tx_status, tx_data1, tx_data2, tx_bits;
   logic                 tx_trigger, tx_busy, err_timeout;
   logic [2:0]           grant_idx;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   tx_mode = 0;
   msg_t stim_q [N_REQ][$];
   msg_t exp_q  [N_REQ][$];

   int               m_phase = 0;
   int               idle_from = 0;
   int               trig_edge = 0;
   int               last_g = N_REQ - 1;
   msg_t             cur = '0;
   msg_t             popped;
   logic [N_REQ-1:0] exp_ack;
   int               exp_trig, exp_err, g, a;

   always #5 clk = ~clk;

   midi_tx_arbiter #(.N_REQ(N_REQ), .GAP_CYCLES(GAP), .START_TIMEOUT(TOUT)) dut (
      .clk(clk), .rst(rst), .req(req), .req_status(req_status), .req_data1(req_data1),
      .req_data2(req_data2), .req_len(req_len), .ack(ack), .tx_status(tx_status),
      .tx_data1(tx_data1), .tx_data2(tx_data2), .tx_bits(tx_bits), .tx_trigger(tx_trigger),
      .tx_busy(tx_busy), .grant_idx(grant_idx), .err_timeout(err_timeout)
   );

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int src, input logic [7:0] st, input logic [7:0] d1,
                                input logic [7:0] d2, input logic [1:0] len);
      msg_t m;
      m = '{st: st, d1: d1, d2: d2, len: len};
      stim_q[src].push_back(m);
      exp_q[src].push_back(m);
   endtask

   task automatic presentMsg(input int src, input msg_t m);
      req_status[8*src +: 8] = m.st;
      req_data1[8*src +: 8]  = m.d1;
      req_data2[8*src +: 8]  = m.d2;
      req_len[2*src +: 2]    = m.len;
      req[src]               = 1'b1;
   endtask

   function automatic int rrPick(input int last, input logic [N_REQ-1:0] r);
      for (int k = 1; k <= N_REQ; k++)
         if (r[(last + k) % N_REQ]) return (last + k) % N_REQ;
      return -1;
   endfunction

   function automatic bit allQueuesEmpty();
      for (int i = 0; i < N_REQ; i++)
         if (stim_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic waitIdle(input int budget);
      int n;
      n = 0;
      while (!(allQueuesEmpty() && req == '0 && m_phase == 0 && cyc >= idle_from && !tx_busy)
             && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("[TB] FAIL wait_idle: budget of %0d cycles expired at cycle %0d", budget, cyc);
      end
   endtask

   // Requesters: hold a message until acked, then present the next queued one or drop req.
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < N_REQ; i++) begin
            if (req[i] && ack[i]) begin
               if (stim_q[i].size() > 0) presentMsg(i, stim_q[i].pop_front());
               else req[i] = 1'b0;
            end else if (!req[i] && stim_q[i].size() > 0) begin
               presentMsg(i, stim_q[i].pop_front());
            end
         end
      end
   end

   // Transmitter: answers a trigger with busy one cycle later, unless it is modelled as dead.
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_trigger && tx_mode == 0 && !rst) begin
            @(negedge clk);
            tx_busy = 1'b1;
            repeat (BUSY_LEN) @(negedge clk);
            tx_busy = 1'b0;
         end
      end
   end

   // Monitor: predicts each edge from the arbitration rules and scores acked messages.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (rst) begin
            m_phase   = 0;
            idle_from = cyc + 1;
            last_g    = N_REQ - 1;
            cur       = '0;
         end else begin
            exp_ack  = '0;
            exp_trig = 0;
            exp_err  = 0;
            case (m_phase)
               0: if (cyc >= idle_from && req != '0) begin
                  g = rrPick(last_g, req);
                  exp_ack[g] = 1'b1;
                  if (exp_q[g].size() > 0) cur = exp_q[g][0];
                  last_g = g;
                  if (cur.len != 2'd0) begin
                     exp_trig  = 1;
                     m_phase   = 1;
                     trig_edge = cyc;
                  end else begin
                     idle_from = cyc + 1;
                  end
               end
               1: begin
                  if (tx_busy) begin
                     m_phase = 2;
                  end else if (cyc - trig_edge == TOUT) begin
                     exp_err   = 1;
                     m_phase   = 0;
                     idle_from = cyc + GAP + 1;
                  end else begin
                     exp_trig = 1;
                  end
               end
               default: if (!tx_busy) begin
                  m_phase   = 0;
                  idle_from = cyc + GAP + 1;
               end
            endcase

            if (ack != '0) begin
               a = 0;
               for (int i = N_REQ - 1; i >= 0; i--) if (ack[i]) a = i;
               checkOutput("sb_ack_has_pending", int'(exp_q[a].size() > 0), 1);
               if (exp_q[a].size() > 0) begin
                  popped = exp_q[a].pop_front();
                  checkOutput("sb_tx_status", tx_status, popped.st);
                  checkOutput("sb_tx_data1", tx_data1, popped.d1);
                  checkOutput("sb_tx_data2", tx_data2, popped.d2);
                  checkOutput("sb_tx_bits", tx_bits, int'(popped.len) * 10);
               end
            end

            checkOutput("ack", ack, exp_ack);
            checkOutput("tx_trigger", tx_trigger, exp_trig);
            checkOutput("err_timeout", err_timeout, exp_err);
            checkOutput("grant_idx", grant_idx, last_g);
            checkOutput("hold_tx_status", tx_status, cur.st);
            checkOutput("hold_tx_data1", tx_data1, cur.d1);
            checkOutput("hold_tx_data2", tx_data2, cur.d2);
            checkOutput("hold_tx_bits", tx_bits, int'(cur.len) * 10);
         end
      end
   end

   initial begin
      int n;
      rst        = 1'b1;
      req        = '0;
      req_status = '0;
      req_data1  = '0;
      req_data2  = '0;
      req_len    = '0;
      repeat (3) @(negedge clk);
      checkOutput("rst_ack", ack, 0);
      checkOutput("rst_tx_trigger", tx_trigger, 0);
      checkOutput("rst_tx_bits", tx_bits, 0);
      checkOutput("rst_tx_status", tx_status, 0);
      checkOutput("rst_grant_idx", grant_idx, N_REQ - 1);
      checkOutput("rst_err_timeout", err_timeout, 0);
      rst = 1'b0;

      $display("[TB] single three-byte message from source 0");
      applyStimulus(0, 8'hB0, 8'h2E, 8'h7F, 2'd3);
      waitIdle(200);

      $display("[TB] both sources held continuously");
      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, 8'h90 + 8'(k), 8'($urandom), 8'($urandom), 2'($urandom_range(1, 3)));
         applyStimulus(1, 8'hA0 + 8'(k), 8'($urandom), 8'($urandom), 2'($urandom_range(1, 3)));
      end
      waitIdle(600);

      $display("[TB] two-byte program change from source 1");
      applyStimulus(1, 8'hC0, 8'h42, 8'h00, 2'd2);
      waitIdle(200);

      $display("[TB] transmitter never starts");
      tx_mode = 1;
      applyStimulus(0, 8'h91, 8'h3C, 8'h64, 2'd3);
      applyStimulus(1, 8'h81, 8'h3C, 8'h00, 2'd3);
      waitIdle(200);
      tx_mode = 0;

      $display("[TB] zero-length message then a real one");
      applyStimulus(0, 8'hF8, 8'h00, 8'h00, 2'd0);
      applyStimulus(1, 8'hB1, 8'h07, 8'h40, 2'd3);
      waitIdle(200);

      $display("[TB] randomized traffic");
      for (int k = 0; k < 40; k++) begin
         applyStimulus($urandom_range(0, N_REQ - 1), 8'($urandom), 8'($urandom), 8'($urandom),
                       2'($urandom_range(0, 3)));
         repeat ($urandom_range(0, 30)) @(negedge clk);
      end
      waitIdle(3000);

      $display("[TB] reset while transmitter busy");
      applyStimulus(1, 8'h92, 8'h40, 8'h50, 2'd3);
      n = 0;
      while (!tx_busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("busy_seen_before_reset", int'(tx_busy), 1);
      applyStimulus(0, 8'h93, 8'h41, 8'h51, 2'd3);
      applyStimulus(1, 8'h94, 8'h42, 8'h52, 2'd2);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_rst_ack", ack, 0);
      checkOutput("async_rst_tx_trigger", tx_trigger, 0);
      checkOutput("async_rst_tx_status", tx_status, 0);
      checkOutput("async_rst_tx_bits", tx_bits, 0);
      checkOutput("async_rst_grant_idx", grant_idx, N_REQ - 1);
      checkOutput("async_rst_err_timeout", err_timeout, 0);
      n = 0;
      while (tx_busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      rst = 1'b0;
      waitIdle(300);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
